// File: rtl/ledger_mem_sequencer.sv
// Arbitrated sequencer for the shared balance RAM: a store channel writes p1/p2 amounts, a fetch channel reads them back.
// Optional LEDGER_VERIFY_EN: stores read back all four bytes and flag mismatches on store_error.
module ledger_mem_sequencer #(
    parameter int RD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        store_req,
    input  logic [10:0] p1_amount_in,
    input  logic [10:0] p2_amount_in,
    output logic        store_done,
    output logic        store_error,
    input  logic        fetch_req,
    output logic        fetch_done,
    output logic [10:0] p1_amount_rd,
    output logic [10:0] p2_amount_rd,
    output logic        busy,
    output logic        access_p2,
    output logic [1:0]  access_type,
    output logic [7:0]  data_in,
    output logic        wren,
    input  logic [7:0]  result
);

    typedef enum logic [2:0] {IDLE, WR, RD, DONE_S, DONE_F} state_t;

    state_t      state, state_nx;
    logic [1:0]  slot;
    logic [1:0]  lat;
    logic        last_lat;
    logic        vfy;
    logic [10:0] p1_amt, p2_amt;
    logic [10:0] wr_amt;
    logic [7:0]  wr_byte;
    logic [7:0]  cap_p1lo, cap_p2lo;
    logic [2:0]  cap_p1hi;

    assign last_lat = (lat == 2'(RD_LAT));
    // slot[1] picks the player, slot[0] picks the byte field
    assign wr_amt   = slot[1] ? p2_amt : p1_amt;
    assign wr_byte  = slot[0] ? {5'b0, wr_amt[10:8]} : wr_amt[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            slot  <= 2'd0;
            lat   <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                slot <= 2'd0;
                lat  <= 2'd0;
            end else if (state == WR) begin
                slot <= slot + 2'd1;
            end else if (state == RD) begin
                if (last_lat) begin
                    lat  <= 2'd0;
                    slot <= slot + 2'd1;
                end else begin
                    lat <= lat + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (store_req) state_nx = WR;
                    else if (fetch_req) state_nx = RD;
            WR:     if (slot == 2'd3) state_nx = vfy ? RD : DONE_S;
            RD:     if (last_lat && slot == 2'd3) state_nx = vfy ? DONE_S : DONE_F;
            DONE_S: state_nx = IDLE;
            DONE_F: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wren        = 1'b0;
        access_p2   = 1'b0;
        access_type = 2'b00;
        data_in     = 8'h00;
        store_done  = 1'b0;
        fetch_done  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            WR: begin
                wren        = 1'b1;
                access_p2   = slot[1];
                access_type = {1'b0, slot[0]};
                data_in     = wr_byte;
            end
            RD: begin
                access_p2   = slot[1];
                access_type = {1'b0, slot[0]};
            end
            DONE_S:  store_done = 1'b1;
            DONE_F:  fetch_done = 1'b1;
            default: ;
        endcase
    end

    // Read bytes are staged so both amounts change together on the fetch_done edge
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_amt       <= 11'd0;
            p2_amt       <= 11'd0;
            cap_p1lo     <= 8'd0;
            cap_p1hi     <= 3'd0;
            cap_p2lo     <= 8'd0;
            p1_amount_rd <= 11'd0;
            p2_amount_rd <= 11'd0;
        end else begin
            if (state == IDLE && store_req) begin
                p1_amt <= p1_amount_in;
                p2_amt <= p2_amount_in;
            end
            if (state == RD && last_lat && !vfy) begin
                case (slot)
                    2'd0: cap_p1lo <= result;
                    2'd1: cap_p1hi <= result[2:0];
                    2'd2: cap_p2lo <= result;
                    default: begin
                        p1_amount_rd <= {cap_p1hi, cap_p1lo};
                        p2_amount_rd <= {result[2:0], cap_p2lo};
                    end
                endcase
            end
        end
    end

`ifdef LEDGER_VERIFY_EN
    logic mism;
    logic err;

    // vfy marks RD slots that belong to a store readback rather than a fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            vfy  <= 1'b0;
            mism <= 1'b0;
            err  <= 1'b0;
        end else if (state == IDLE && store_req) begin
            vfy  <= 1'b1;
            mism <= 1'b0;
            err  <= 1'b0;
        end else if (state == IDLE && fetch_req) begin
            vfy <= 1'b0;
        end else if (state == RD && vfy && last_lat) begin
            if (slot == 2'd3) err <= mism | (result != wr_byte);
            else              mism <= mism | (result != wr_byte);
        end
    end

    assign store_error = err;
`else
    logic unused_hi;

    assign vfy         = 1'b0;
    assign store_error = 1'b0;
    assign unused_hi   = &{1'b0, result[7:3]};
`endif

endmodule

// File: tb/tb_ledger_mem_sequencer.sv
// Randomized self-checking bench for ledger_mem_sequencer with a behavioural RAM and a ledger-level reference model.
module tb_ledger_mem_sequencer;
    localparam int RD_LAT = 1;
`ifdef LEDGER_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int ST_LAT = VFY ? 5 + 4 * (RD_LAT + 1) : 5;
    localparam int FE_LAT = 1 + 4 * (RD_LAT + 1);

    logic        clock = 1'b0;
    logic        reset, store_req, fetch_req;
    logic [10:0] p1_in, p2_in;
    logic        store_done, store_error, fetch_done, busy;
    logic [10:0] p1_amount_rd, p2_amount_rd;
    logic        access_p2, wren;
    logic [1:0]  access_type;
    logic [7:0]  data_in, result;

    int total = 0;
    int bad   = 0;

    logic [10:0] m1 = 11'd0, m2 = 11'd0;
    logic [10:0] last1 = 11'd0, last2 = 11'd0;
    bit          corrupt = 1'b0;
    logic [10:0] wlog [$];
    logic [7:0]  mem [4];
    logic [7:0]  rpipe [RD_LAT];

    ledger_mem_sequencer #(.RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .store_req(store_req), .p1_amount_in(p1_in), .p2_amount_in(p2_in),
        .store_done(store_done), .store_error(store_error),
        .fetch_req(fetch_req), .fetch_done(fetch_done),
        .p1_amount_rd(p1_amount_rd), .p2_amount_rd(p2_amount_rd),
        .busy(busy), .access_p2(access_p2), .access_type(access_type),
        .data_in(data_in), .wren(wren), .result(result)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        for (int i = 0; i < RD_LAT; i++) rpipe[i] = 8'h00;
    end

    // RAM with RD_LAT cycles from stable address to valid result; corrupt flips bit 7 of (p2,hi)
    always @(posedge clock) begin
        if (wren)
            mem[{access_p2, access_type[0]}] <= (corrupt && access_p2 && access_type[0]) ? data_in ^ 8'h80 : data_in;
        rpipe[0] <= mem[{access_p2, access_type[0]}];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign result = rpipe[RD_LAT-1];

    always @(posedge clock) if (wren) wlog.push_back({access_p2, access_type, data_in});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input bit st, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(st ? store_done : fetch_done) && n < 400);
    endtask

    function automatic logic [10:0] wexp(input logic [10:0] a1, input logic [10:0] a2, input int i);
        logic [10:0] a;
        a = (i >= 2) ? a2 : a1;
        return (i % 2 == 1) ? {i >= 2, 2'b01, 5'b0, a[10:8]} : {i >= 2, 2'b00, a[7:0]};
    endfunction

    task automatic do_store(input logic [10:0] a1, input logic [10:0] a2, input bit bad_ram);
        int n;
        @(negedge clock);
        corrupt = bad_ram;
        wlog.delete();
        p1_in = a1; p2_in = a2; store_req = 1'b1;
        @(posedge clock); #1;
        p1_in = 11'($urandom); p2_in = 11'($urandom);
        wait_done(1'b1, n);
        store_req = 1'b0;
        chk("st_lat", 32'(n), 32'(ST_LAT));
        chk("st_err", 32'(store_error), 32'(VFY && bad_ram));
        chk("st_wcnt", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk($sformatf("st_w%0d", i), 32'(wlog[i]), 32'(wexp(a1, a2, i)));
        chk("st_rd_hold", {10'd0, p1_amount_rd, p2_amount_rd}, {10'd0, last1, last2});
        m1 = a1; m2 = a2;
        @(negedge clock);
        chk("st_err_hold", 32'(store_error), 32'(VFY && bad_ram));
        chk("st_idle", 32'(busy), 32'd0);
        corrupt = 1'b0;
    endtask

    task automatic do_fetch();
        int n;
        @(negedge clock);
        fetch_req = 1'b1;
        @(posedge clock); #1;
        wait_done(1'b0, n);
        fetch_req = 1'b0;
        chk("fe_lat", 32'(n), 32'(FE_LAT));
        chk("fe_p1", 32'(p1_amount_rd), 32'(m1));
        chk("fe_p2", 32'(p2_amount_rd), 32'(m2));
        last1 = m1; last2 = m2;
    endtask

    initial begin
        int n;
        logic [10:0] a1, a2;
        reset = 1'b1; store_req = 1'b0; fetch_req = 1'b0; p1_in = 11'd0; p2_in = 11'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_rd", {10'd0, p1_amount_rd, p2_amount_rd}, 32'd0);
            chk("idle_ctl", {16'd0, store_done, store_error, fetch_done, busy,
                             access_p2, access_type, data_in, wren}, 32'd0);
        end

        do_store(11'h5A3, 11'h07F, 1'b0);
        do_fetch();

        // simultaneous requests: store first, fetch one IDLE cycle after store_done
        a1 = 11'($urandom); a2 = 11'($urandom);
        @(negedge clock);
        p1_in = a1; p2_in = a2; store_req = 1'b1; fetch_req = 1'b1;
        @(posedge clock); #1;
        wait_done(1'b1, n);
        store_req = 1'b0;
        chk("sim_st_lat", 32'(n), 32'(ST_LAT));
        m1 = a1; m2 = a2;
        wait_done(1'b0, n);
        fetch_req = 1'b0;
        chk("sim_fe_lat", 32'(n), 32'(FE_LAT + 1));
        chk("sim_p1", 32'(p1_amount_rd), 32'(m1));
        chk("sim_p2", 32'(p2_amount_rd), 32'(m2));
        last1 = m1; last2 = m2;

        // reset during the third write slot: (p1,lo),(p1,hi),(p2,lo) land, (p2,hi) does not
        a1 = 11'($urandom); a2 = 11'($urandom);
        @(negedge clock);
        wlog.delete();
        p1_in = a1; p2_in = a2; store_req = 1'b1;
        @(posedge clock); #1;
        repeat (3) @(negedge clock);
        reset = 1'b1; store_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_done", 32'(store_done), 32'd0);
        chk("rst_rd", {10'd0, p1_amount_rd, p2_amount_rd}, 32'd0);
        chk("rst_err", 32'(store_error), 32'd0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_nodone", {30'd0, store_done, wren}, 32'd0);
        end
        chk("rst_wcnt", 32'(wlog.size()), 32'd3);
        m1 = a1; m2 = {m2[10:8], a2[7:0]};
        last1 = 11'd0; last2 = 11'd0;
        do_fetch();

        // corrupted readback, then a clean store clears the flag
        do_store(11'($urandom), 11'($urandom), 1'b1);
        do_fetch();
        do_store(11'($urandom), 11'($urandom), 1'b0);

        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 0) do_store(11'($urandom), 11'($urandom), 1'b0);
            else                           do_fetch();
        end
        do_store(11'h7FF, 11'h000, 1'b0);
        do_fetch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
